uart_tx_sched: RTL and testbench



---
 rtl/uart_tx_sched.sv | 144 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one tx_string transmitter among N_CH UART pins.
// Define UART_SCHED_PERIODIC_EN to add a timer that requests every channel each PERIOD clocks.
module uart_tx_sched #(
    parameter int unsigned CLK    = 24_000_000,
    parameter int unsigned N_CH   = 8,
    parameter int unsigned PERIOD = 24_000_000
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_req,
    input  logic            i_busy,
    input  logic            i_tx,
    output logic            o_en,
    output logic [15:0]     o_div,
    output logic [N_CH-1:0] o_uart,
    output logic [N_CH-1:0] o_grant,
    output logic            o_done,
    output logic            o_led_tx_l
);
    localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_START, S_ARM1, S_ARM2, S_WAIT, S_DONE
    } state_t;

    state_t          state_q;
    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] pend_set, pend_clr;
    logic [IW-1:0]   last_q, gidx_q;
    logic [IW-1:0]   pick, cand;
    logic            pick_vld;

    function automatic logic [15:0] div_of(input int unsigned k);
        int unsigned baud;
        case (k)
            0:       baud = 1200;
            1:       baud = 2400;
            2:       baud = 4800;
            3:       baud = 9600;
            4:       baud = 19200;
            5:       baud = 38400;
            6:       baud = 57600;
            default: baud = 115200;
        endcase
        return 16'(CLK / (4 * baud));
    endfunction

`ifdef UART_SCHED_PERIODIC_EN
    localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    logic [TW-1:0] tmr_q;
    logic          tmr_wrap;

    assign tmr_wrap = (tmr_q == TW'(PERIOD - 1));
    assign pend_set = tmr_wrap ? '1 : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_wrap ? '0 : tmr_q + TW'(1);
        end
    end
`else
    assign pend_set = '0;
`endif

    // o_grant still holds the served channel while in DONE; OR-ing requests after the clear lets set win.
    assign pend_clr = (state_q == S_DONE) ? o_grant : '0;
    assign pend_d   = (pend_q & ~pend_clr) | i_req | pend_set;

    always_comb begin
        pick     = last_q;
        pick_vld = 1'b0;
        cand     = '0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            cand = IW'((32'(last_q) + i) % N_CH);
            if (!pick_vld && pend_q[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q <= '0;
            o_uart <= '1;
        end else begin
            pend_q <= pend_d;
            o_uart <= ~o_grant | ({N_CH{i_tx}} & o_grant);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            o_en       <= 1'b0;
            o_div      <= '0;
            o_grant    <= '0;
            o_done     <= 1'b0;
            o_led_tx_l <= 1'b1;
            last_q     <= IW'(N_CH - 1);
            gidx_q     <= '0;
        end else begin
            o_en   <= 1'b0;
            o_done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        gidx_q  <= pick;
                        o_grant <= N_CH'(1) << pick;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    o_div   <= div_of(32'(gidx_q));
                    state_q <= S_START;
                end
                S_START: begin
                    if (!i_busy) begin
                        o_en       <= 1'b1;
                        o_led_tx_l <= 1'b0;
                        state_q    <= S_ARM1;
                    end
                end
                S_ARM1: state_q <= S_ARM2;
                S_ARM2: state_q <= S_WAIT;
                S_WAIT: begin
                    if (!i_busy) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_done     <= 1'b1;
                    last_q     <= gidx_q;
                    o_led_tx_l <= 1'b1;
                    o_grant    <= '0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a behavioural tx_string stand-in.
// Define UART_SCHED_PERIODIC_EN to exercise the periodic-request build.
module tb_uart_tx_sched;
    localparam int N = 8;
`ifdef UART_SCHED_PERIODIC_EN
    localparam int TB_PERIOD = 1000;
`else
    localparam int TB_PERIOD = 24_000_000;
`endif
    localparam int DIVS [8] = '{5000, 2500, 1250, 625, 312, 156, 104, 52};

    logic        clk, rst_n;
    logic [7:0]  i_req;
    logic        i_busy, i_tx, mdl_busy, hold_busy;
    logic        o_en, o_done, o_led_tx_l;
    logic [15:0] o_div;
    logic [7:0]  o_uart, o_grant;

    int n_checks = 0;
    int n_errors = 0;
    int busy_len = 10;

    assign i_busy = mdl_busy | hold_busy;

    uart_tx_sched #(.CLK(24_000_000), .N_CH(8), .PERIOD(TB_PERIOD)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_busy(i_busy), .i_tx(i_tx),
        .o_en(o_en), .o_div(o_div), .o_uart(o_uart), .o_grant(o_grant),
        .o_done(o_done), .o_led_tx_l(o_led_tx_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // tx_string stand-in: busy one clock after the start pulse, random line bits while busy.
    initial begin
        mdl_busy = 1'b0;
        i_tx     = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (o_en === 1'b1 && rst_n === 1'b1) begin
                @(posedge clk); #1;
                mdl_busy = 1'b1;
                for (int k = 0; k < busy_len; k++) begin
                    @(posedge clk); #1;
                    i_tx = 1'($urandom_range(0, 1));
                end
                i_tx     = 1'b1;
                mdl_busy = 1'b0;
            end
        end
    end

    function automatic int next_ch(input logic [7:0] p, input int last);
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (last + i) % N;
            if (p[c]) return c;
        end
        return -1;
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; i_req = '0; hold_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_model_idle;
        for (int c = 0; c < 500 && mdl_busy === 1'b1; c++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; i_req = '0; hold_busy = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (o_uart !== 8'hFF) begin n_errors++; $display("FAIL rst_uart: got %h want ff", o_uart); end
        n_checks++; if (o_en !== 1'b0) begin n_errors++; $display("FAIL rst_en: got %b want 0", o_en); end
        n_checks++; if (o_div !== 16'd0) begin n_errors++; $display("FAIL rst_div: got %0d want 0", o_div); end
        n_checks++; if (o_grant !== 8'h00) begin n_errors++; $display("FAIL rst_grant: got %h want 00", o_grant); end
        n_checks++; if (o_done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %b want 0", o_done); end
        n_checks++; if (o_led_tx_l !== 1'b1) begin n_errors++; $display("FAIL rst_led: got %b want 1", o_led_tx_l); end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++; if (o_grant !== 8'h00) begin n_errors++; $display("FAIL rst_idle_grant: got %h want 00", o_grant); end
    endtask

    task automatic test_single;
        logic       prev_tx;
        logic [7:0] exp_u;
        bit         seen;
        int         en_cnt;
        busy_len = 12;
        do_reset();
        i_req = 8'h08;
        @(negedge clk); i_req = '0;
        n_checks++; if (o_grant !== 8'h00) begin n_errors++; $display("FAIL one_grant_e0: got %h want 00", o_grant); end
        @(negedge clk);
        n_checks++; if (o_grant !== 8'h08) begin n_errors++; $display("FAIL one_grant_e1: got %h want 08", o_grant); end
        @(negedge clk);
        n_checks++; if (o_div !== 16'd625) begin n_errors++; $display("FAIL one_div_e2: got %0d want 625", o_div); end
        n_checks++; if (o_en !== 1'b0) begin n_errors++; $display("FAIL one_en_e2: got %b want 0", o_en); end
        prev_tx = i_tx;
        @(negedge clk);
        n_checks++; if (o_en !== 1'b1) begin n_errors++; $display("FAIL one_en_e3: got %b want 1", o_en); end
        n_checks++; if (o_led_tx_l !== 1'b0) begin n_errors++; $display("FAIL one_led_e3: got %b want 0", o_led_tx_l); end
        seen = 0; en_cnt = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            exp_u = 8'hFF;
            exp_u[3] = prev_tx;
            n_checks++; if (o_uart !== exp_u) begin n_errors++; $display("FAIL one_route: got %h want %h", o_uart, exp_u); end
            n_checks++; if (o_div !== 16'd625) begin n_errors++; $display("FAIL one_div_hold: got %0d want 625", o_div); end
            if (o_en === 1'b1) en_cnt++;
            if (o_done === 1'b1) seen = 1;
            prev_tx = i_tx;
            if (!seen) @(negedge clk);
        end
        n_checks++; if (seen !== 1'b1) begin n_errors++; $display("FAIL one_done_timeout: got %b want 1", seen); end
        n_checks++; if (en_cnt != 1) begin n_errors++; $display("FAIL one_en_count: got %0d want 1", en_cnt); end
        n_checks++; if (o_grant !== 8'h00) begin n_errors++; $display("FAIL one_grant_done: got %h want 00", o_grant); end
        n_checks++; if (o_led_tx_l !== 1'b1) begin n_errors++; $display("FAIL one_led_done: got %b want 1", o_led_tx_l); end
        @(negedge clk);
        n_checks++; if (o_done !== 1'b0) begin n_errors++; $display("FAIL one_done_pulse: got %b want 0", o_done); end
        n_checks++; if (o_uart !== 8'hFF) begin n_errors++; $display("FAIL one_uart_idle: got %h want ff", o_uart); end
        wait_model_idle();
    endtask

    task automatic test_all_channels;
        logic [7:0] pend_m;
        int         last_m, exp_ch, cyc, led_bad, dones;
        logic [7:0] exp_g;
        busy_len = 100;
        do_reset();
        pend_m = 8'hFF; last_m = N - 1; dones = 0;
        i_req = 8'hFF;
        @(negedge clk); i_req = '0;
        for (int t = 0; t < N; t++) begin
            exp_ch = next_ch(pend_m, last_m);
            exp_g  = 8'(1) << exp_ch;
            cyc = 0;
            while (o_grant === 8'h00 && cyc < 50) begin @(negedge clk); cyc++; end
            n_checks++; if (o_grant !== exp_g) begin n_errors++; $display("FAIL all_grant%0d: got %h want %h", t, o_grant, exp_g); end
            cyc = 0;
            while (o_en !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
            n_checks++; if (o_div !== 16'(DIVS[exp_ch])) begin n_errors++; $display("FAIL all_div%0d: got %0d want %0d", t, o_div, DIVS[exp_ch]); end
            led_bad = 0; cyc = 0;
            while (o_done !== 1'b1 && cyc < 400) begin
                if (o_led_tx_l !== 1'b0) led_bad++;
                @(negedge clk); cyc++;
            end
            if (o_done === 1'b1) dones++;
            n_checks++; if (led_bad != 0) begin n_errors++; $display("FAIL all_led_low%0d: got %0d high cycles want 0", t, led_bad); end
            n_checks++; if (o_led_tx_l !== 1'b1) begin n_errors++; $display("FAIL all_led_done%0d: got %b want 1", t, o_led_tx_l); end
            pend_m[exp_ch] = 1'b0;
            last_m = exp_ch;
        end
        n_checks++; if (dones != N) begin n_errors++; $display("FAIL all_done_count: got %0d want %0d", dones, N); end
        repeat (20) @(negedge clk);
        n_checks++; if (o_grant !== 8'h00) begin n_errors++; $display("FAIL all_idle: got %h want 00", o_grant); end
        wait_model_idle();
    endtask

    task automatic test_set_wins;
        int cyc, served, en_cnt;
        busy_len = 20;
        do_reset();
        served = 0;
        i_req = 8'h04;
        for (int t = 0; t < 2; t++) begin
            cyc = 0;
            while (o_grant === 8'h00 && cyc < 50) begin @(negedge clk); cyc++; end
            n_checks++; if (o_grant !== 8'h04) begin n_errors++; $display("FAIL sw_grant%0d: got %h want 04", t, o_grant); end
            cyc = 0;
            while (o_done !== 1'b1 && cyc < 300) begin @(negedge clk); cyc++; end
            if (o_done === 1'b1) served++;
            i_req = '0;
            @(negedge clk);
        end
        n_checks++; if (served != 2) begin n_errors++; $display("FAIL sw_served: got %0d want 2", served); end
        en_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (o_en === 1'b1 || o_grant !== 8'h00) en_cnt++;
            @(negedge clk);
        end
        n_checks++; if (en_cnt != 0) begin n_errors++; $display("FAIL sw_back_idle: got %0d active cycles want 0", en_cnt); end
        wait_model_idle();
    endtask

    task automatic test_busy_held;
        int en_cnt, cyc;
        busy_len = 10;
        do_reset();
        hold_busy = 1'b1;
        i_req = 8'h02;
        @(negedge clk); i_req = '0;
        en_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (o_en === 1'b1) en_cnt++;
        end
        n_checks++; if (en_cnt != 0) begin n_errors++; $display("FAIL bh_no_pulse: got %0d pulses want 0", en_cnt); end
        n_checks++; if (o_grant !== 8'h02) begin n_errors++; $display("FAIL bh_grant: got %h want 02", o_grant); end
        n_checks++; if (o_div !== 16'd2500) begin n_errors++; $display("FAIL bh_div: got %0d want 2500", o_div); end
        n_checks++; if (o_led_tx_l !== 1'b1) begin n_errors++; $display("FAIL bh_led: got %b want 1", o_led_tx_l); end
        hold_busy = 1'b0;
        en_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (o_en === 1'b1) en_cnt++;
        end
        n_checks++; if (en_cnt != 1) begin n_errors++; $display("FAIL bh_one_pulse: got %0d pulses want 1", en_cnt); end
        cyc = 0;
        while (o_done !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        n_checks++; if (o_done !== 1'b1) begin n_errors++; $display("FAIL bh_done: got %b want 1", o_done); end
        wait_model_idle();
    endtask

    task automatic test_reset_mid;
        int cyc, act;
        busy_len = 60;
        do_reset();
        i_req = 8'h20;
        @(negedge clk); i_req = '0;
        cyc = 0;
        while (o_en !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        repeat (10) @(negedge clk);
        n_checks++; if (o_grant !== 8'h20) begin n_errors++; $display("FAIL rm_grant_pre: got %h want 20", o_grant); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (o_uart !== 8'hFF) begin n_errors++; $display("FAIL rm_uart: got %h want ff", o_uart); end
        n_checks++; if (o_grant !== 8'h00) begin n_errors++; $display("FAIL rm_grant: got %h want 00", o_grant); end
        n_checks++; if (o_led_tx_l !== 1'b1) begin n_errors++; $display("FAIL rm_led: got %b want 1", o_led_tx_l); end
        n_checks++; if (o_div !== 16'd0) begin n_errors++; $display("FAIL rm_div: got %0d want 0", o_div); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_model_idle();
        act = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_grant !== 8'h00 || o_en === 1'b1) act++;
        end
        n_checks++; if (act != 0) begin n_errors++; $display("FAIL rm_pend_cleared: got %0d active cycles want 0", act); end
    endtask

`ifdef UART_SCHED_PERIODIC_EN
    task automatic test_periodic;
        int cyc;
        logic [7:0] exp_g;
        busy_len = 5;
        do_reset();
        cyc = 1;
        while (o_grant === 8'h00 && cyc < 1100) begin @(negedge clk); cyc++; end
        n_checks++; if (cyc < 1000 || cyc > 1002) begin n_errors++; $display("FAIL per_first_grant_cycle: got %0d want 1001", cyc); end
        for (int t = 0; t < N; t++) begin
            exp_g = 8'(1) << t;
            cyc = 0;
            while (o_grant === 8'h00 && cyc < 50) begin @(negedge clk); cyc++; end
            n_checks++; if (o_grant !== exp_g) begin n_errors++; $display("FAIL per_grant%0d: got %h want %h", t, o_grant, exp_g); end
            cyc = 0;
            while (o_done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; i_req = '0; hold_busy = 1'b0;
        test_reset();
`ifdef UART_SCHED_PERIODIC_EN
        test_periodic();
`else
        test_single();
        test_all_channels();
        test_set_wins();
        test_busy_held();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
